dmem_arbiter: RTL and testbench

//  Shares the single-port data memory (word-aligned address, async read, write on

---
 rtl/dmem_pkg.sv | 45 ++++
 rtl/dmem_lane_align.sv | 53 +++++
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data-memory arbiter.
// Access sizes, FSM state encoding and byte-lane utilities live here.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;

    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       uns;
    } req_ctl_t;

    // Misaligned halves/words and the reserved size never touch memory.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] lo2);
        logic e;
        e = 1'b1;
        case (size)
            SZ_BYTE: e = 1'b0;
            SZ_HALF: e = lo2[0];
            SZ_WORD: e = (lo2 != 2'b00);
            SZ_ILL:  e = 1'b1;
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo2);
        logic [3:0] m;
        m = 4'b1111;
        case (size)
            SZ_BYTE: m = 4'b0001 << lo2;
            SZ_HALF: m = lo2[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: load extraction with sign/zero extension,
// and replacement of the addressed lane(s) in an old word for sub-word stores.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lo2,
    input  logic        uns,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] rep;
    logic [3:0]  mask;

    always_comb begin
        sel_byte = rd_word[7:0];
        case (lo2)
            2'd1:    sel_byte = rd_word[15:8];
            2'd2:    sel_byte = rd_word[23:16];
            2'd3:    sel_byte = rd_word[31:24];
            default: sel_byte = rd_word[7:0];
        endcase
        sel_half = lo2[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = rd_word;
        case (size)
            SZ_BYTE: load_val = uns ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            SZ_HALF: load_val = uns ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
            default: load_val = rd_word;
        endcase
    end

    // Store data is replicated across lanes so the mask alone picks what lands.
    always_comb begin
        mask   = lane_mask(size, lo2);
        rep    = wdata;
        merged = old_word;
        case (size)
            SZ_BYTE: rep = {4{wdata[7:0]}};
            SZ_HALF: rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
        for (int k = 0; k < 4; k++) begin
            merged[8*k +: 8] = mask[k] ? rep[8*k +: 8] : old_word[8*k +: 8];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the word-only data memory between the CPU (port 0)
// and the loader (port 1), adding byte/halfword loads and read-modify-write stores.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int FIRST_PRI = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [1:0]    p0_size,
    input  logic          p0_unsigned,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_done,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_err,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [1:0]    p1_size,
    input  logic          p1_unsigned,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_done,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_err,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd
);
    import dmem_pkg::*;

    logic [1:0]    state;
    logic          rr_ptr;
    logic          cur_port;
    req_ctl_t      cur_ctl;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;
    logic [DW-1:0] merge_q;
    logic [DW-1:0] load_val;
    logic [DW-1:0] merged;
    logic          acc_err;
    logic          fin;
    logic          fin_err;
    logic          fin_load;

    // rr_ptr names the port preferred when both request at once.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst && state == ST_IDLE) begin
            if (p0_req && (!p1_req || !rr_ptr)) begin
                p0_gnt = 1'b1;
            end else if (p1_req) begin
                p1_gnt = 1'b1;
            end
        end
    end

    assign acc_err = access_err(cur_ctl.size, cur_addr[1:0]);
    assign mem_a   = {cur_addr[AW-1:2], 2'b00};

    always_comb begin
        fin      = 1'b0;
        fin_err  = 1'b0;
        fin_load = 1'b0;
        mem_we   = 1'b0;
        mem_wd   = cur_wdata;
        case (state)
            ST_ACCESS: begin
                fin_err  = acc_err;
                fin_load = !acc_err && !cur_ctl.we;
                fin      = acc_err || !cur_ctl.we || (cur_ctl.size == SZ_WORD);
                mem_we   = !acc_err && cur_ctl.we && (cur_ctl.size == SZ_WORD);
            end
            ST_WRITE: begin
                fin    = 1'b1;
                mem_we = 1'b1;
                mem_wd = merged;
            end
            default: begin
                fin = 1'b0;
            end
        endcase
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    dmem_lane_align u_align (
        .rd_word  (mem_rd),
        .old_word (merge_q),
        .wdata    (cur_wdata),
        .size     (cur_ctl.size),
        .lo2      (cur_addr[1:0]),
        .uns      (cur_ctl.uns),
        .load_val (load_val),
        .merged   (merged)
    );

    // Done/err are single-cycle pulses; rdata holds until that port's next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= FIRST_PRI[0];
            cur_port  <= 1'b0;
            cur_ctl   <= '0;
            cur_addr  <= '0;
            cur_wdata <= '0;
            merge_q   <= '0;
            p0_done   <= 1'b0;
            p1_done   <= 1'b0;
            p0_err    <= 1'b0;
            p1_err    <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_done <= fin && !cur_port;
            p1_done <= fin && cur_port;
            p0_err  <= fin_err && !cur_port;
            p1_err  <= fin_err && cur_port;
            if (fin_load && !cur_port) begin
                p0_rdata <= load_val;
            end
            if (fin_load && cur_port) begin
                p1_rdata <= load_val;
            end
            case (state)
                ST_IDLE: begin
                    if (p0_gnt || p1_gnt) begin
                        cur_port  <= p1_gnt;
                        rr_ptr    <= p0_gnt;
                        cur_ctl   <= p1_gnt ? {p1_we, p1_size, p1_unsigned}
                                            : {p0_we, p0_size, p0_unsigned};
                        cur_addr  <= p1_gnt ? p1_addr : p0_addr;
                        cur_wdata <= p1_gnt ? p1_wdata : p0_wdata;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (fin) begin
                        state <= ST_IDLE;
                    end else begin
                        merge_q <= mem_rd;
                        state   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed accesses push expected completions,
// a monitor pops them whenever a done pulse appears.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p0_unsigned, p0_gnt, p0_done, p0_err;
    logic [1:0]  p0_size;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_unsigned, p1_gnt, p1_done, p1_err;
    logic [1:0]  p1_size;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .FIRST_PRI(0)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_unsigned(p0_unsigned),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_done(p0_done),
        .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_unsigned(p1_unsigned),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_done(p1_done),
        .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    logic [31:0] mem [0:63];
    assign mem_rd = (mem_a[31:8] == 24'h0 && mem_a[1:0] == 2'b00) ? mem[mem_a[7:2]] : 32'hBAD0BAD0;
    always @(posedge clk) begin
        if (mem_we && mem_a[31:8] == 24'h0) mem[mem_a[7:2]] <= mem_wd;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          port;
        bit          err;
        bit          chk_rd;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_rd [2];
    int          gnt_cyc [2];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    function automatic void pushExp(input int port, input bit err, input bit chk, input logic [31:0] rd, input int lat);
        exp_t e;
        e.port = port; e.err = err; e.chk_rd = chk; e.rdata = rd; e.lat = lat;
        exp_q.push_back(e);
    endfunction

    // Monitor: completions are retired before grant times are refreshed.
    initial begin
        forever begin
            int   dp;
            exp_t e;
            @(negedge clk);
            if (p0_done || p1_done) begin
                dp = p1_done ? 1 : 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_done: port %0d pulsed done, none required", dp);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("done_port", dp, e.port);
                    checkOutput("err", {31'b0, (dp == 1) ? p1_err : p0_err}, {31'b0, e.err});
                    checkOutput("latency", cyc - gnt_cyc[dp], e.lat);
                    if (e.chk_rd) checkOutput("rdata", (dp == 1) ? p1_rdata : p0_rdata, e.rdata);
                end
            end
            if (p0_gnt) gnt_cyc[0] = cyc;
            if (p1_gnt) gnt_cyc[1] = cyc;
        end
    end

    task automatic applyStimulus(input int port, input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input bit err, input bit chk_rd, input logic [31:0] rd, input int lat);
        int n;
        bit got;
        @(posedge clk); #2;
        if (port == 0) begin
            p0_req = 1'b1; p0_we = we; p0_size = size; p0_unsigned = uns; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_size = size; p1_unsigned = uns; p1_addr = addr; p1_wdata = wdata;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            if ((port == 0 && p0_gnt) || (port == 1 && p1_gnt)) begin
                got = 1'b1;
                if (err) begin
                    pushExp(port, 1'b1, 1'b1, last_rd[port], lat);
                end else begin
                    pushExp(port, 1'b0, chk_rd, rd, lat);
                    if (chk_rd) last_rd[port] = rd;
                end
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL gnt_timeout: port %0d no grant after %0d cycles, grant required", port, n);
        end
        @(posedge clk); #2;
        if (port == 0) p0_req = 1'b0; else p1_req = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout: %0d completions outstanding, 0 required", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int gp [4];
        int gc [4];
        int ng;
        int n;

        rst = 1'b1;
        p0_req = 1'b1; p0_we = 1'b0; p0_size = 2'b10; p0_unsigned = 1'b0; p0_addr = 32'h00; p0_wdata = 32'h0;
        p1_req = 1'b1; p1_we = 1'b0; p1_size = 2'b10; p1_unsigned = 1'b0; p1_addr = 32'h04; p1_wdata = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0]  = 32'hA0A0A0A0;
        mem[1]  = 32'h0B0B0B0B;
        mem[12] = 32'h00008080;
        mem[16] = 32'h12345678;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;

        $display("[TB] reset state with both ports requesting");
        repeat (2) @(negedge clk);
        checkOutput("rst_p0_gnt", {31'b0, p0_gnt}, 32'h0);
        checkOutput("rst_p1_gnt", {31'b0, p1_gnt}, 32'h0);
        checkOutput("rst_mem_we", {31'b0, mem_we}, 32'h0);
        checkOutput("rst_p0_done", {31'b0, p0_done}, 32'h0);
        checkOutput("rst_p1_done", {31'b0, p1_done}, 32'h0);
        checkOutput("rst_p0_err", {31'b0, p0_err}, 32'h0);
        checkOutput("rst_p0_rdata", p0_rdata, 32'h0);
        checkOutput("rst_p1_rdata", p1_rdata, 32'h0);
        checkOutput("rst_mem_a", mem_a, 32'h0);
        @(posedge clk); #2;
        rst = 1'b0;

        $display("[TB] round-robin with continuous requests");
        ng = 0;
        n = 0;
        while (ng < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (p0_gnt) begin
                gp[ng] = 0; gc[ng] = cyc; ng++;
                pushExp(0, 1'b0, 1'b1, 32'hA0A0A0A0, 2);
                last_rd[0] = 32'hA0A0A0A0;
            end else if (p1_gnt) begin
                gp[ng] = 1; gc[ng] = cyc; ng++;
                pushExp(1, 1'b0, 1'b1, 32'h0B0B0B0B, 2);
                last_rd[1] = 32'h0B0B0B0B;
            end
        end
        @(posedge clk); #2;
        p0_req = 1'b0;
        p1_req = 1'b0;
        if (ng < 4) begin
            checks++;
            failures++;
            $display("[TB] FAIL rr_timeout: %0d grants seen, 4 required", ng);
        end
        for (int i = 0; i < ng; i++) checkOutput("rr_order", gp[i], i % 2);
        for (int i = 1; i < ng; i++) checkOutput("rr_gap", gc[i] - gc[i-1], 2);
        waitDrain();

        $display("[TB] word store then load");
        applyStimulus(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 2);
        waitDrain();
        checkOutput("mem_0x10", mem[4], 32'hDEADBEEF);
        applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 2);
        waitDrain();

        $display("[TB] sub-word stores");
        applyStimulus(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 1'b0, 1'b0, 32'h0, 2);
        waitDrain();
        applyStimulus(0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h123456AA, 1'b0, 1'b0, 32'h0, 3);
        waitDrain();
        checkOutput("mem_0x20_byte", mem[8], 32'h1122AA44);
        applyStimulus(1, 1'b1, 2'b01, 1'b0, 32'h22, 32'hCAFEBEEF, 1'b0, 1'b0, 32'h0, 3);
        waitDrain();
        checkOutput("mem_0x20_half", mem[8], 32'hBEEFAA44);
        applyStimulus(1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0, 1'b1, 32'h0000BEEF, 2);
        waitDrain();
        applyStimulus(1, 1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 1'b0, 1'b1, 32'hFFFFFFBE, 2);
        waitDrain();

        $display("[TB] sub-word loads with extension");
        applyStimulus(0, 1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 1'b0, 1'b1, 32'hFFFFFF80, 2);
        applyStimulus(0, 1'b0, 2'b00, 1'b1, 32'h30, 32'h0, 1'b0, 1'b1, 32'h00000080, 2);
        applyStimulus(0, 1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 1'b0, 1'b1, 32'hFFFFFF80, 2);
        applyStimulus(0, 1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 1'b0, 1'b1, 32'h00008080, 2);
        applyStimulus(0, 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 1'b0, 1'b1, 32'h00000000, 2);
        applyStimulus(0, 1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 1'b0, 1'b1, 32'hFFFF8080, 2);
        waitDrain();

        $display("[TB] misaligned and illegal accesses");
        applyStimulus(0, 1'b1, 2'b01, 1'b0, 32'h13, 32'h00005555, 1'b1, 1'b1, 32'h0, 2);
        applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 1'b1, 1'b1, 32'h0, 2);
        applyStimulus(1, 1'b1, 2'b11, 1'b0, 32'h20, 32'h77777777, 1'b1, 1'b1, 32'h0, 2);
        waitDrain();
        checkOutput("mem_0x10_kept", mem[4], 32'hDEADBEEF);
        checkOutput("mem_0x20_kept", mem[8], 32'hBEEFAA44);

        $display("[TB] reset during read-modify-write");
        @(posedge clk); #2;
        p0_req = 1'b1; p0_we = 1'b1; p0_size = 2'b00; p0_unsigned = 1'b0; p0_addr = 32'h40; p0_wdata = 32'h55;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!p0_gnt && n < 50);
        if (!p0_gnt) begin
            checks++;
            failures++;
            $display("[TB] FAIL rmw_gnt_timeout: no grant after %0d cycles, grant required", n);
        end
        @(posedge clk); #2;
        p0_req = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rmw_rst_mem_we", {31'b0, mem_we}, 32'h0);
        checkOutput("rmw_rst_done", {31'b0, p0_done}, 32'h0);
        @(posedge clk); #2;
        rst = 1'b0;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("mem_0x40_kept", mem[16], 32'h12345678);
        checkOutput("rdata_after_rst", p0_rdata, 32'h0);
        applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 32'h12345678, 2);
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
